test_sequencer: RTL and testbench

TEST_SEQUENCER -- requirements
Module: test_sequencer

---
 rtl/test_sequencer.sv | 141 ++++++++++++++
 tb/tb_test_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/test_sequencer.sv
// Test sequencer: walks an enable mask, resets and launches each enabled test,
// tallies pass/fail checks with a per-test watchdog, then reports run totals.
`timescale 1ns/1ps
module test_sequencer #(
  parameter int NUM_TESTS      = 4,
  parameter int CNT_W          = 8,
  parameter int RST_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int IDX_W = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [NUM_TESTS-1:0] test_en,
  input  logic                 check_valid,
  input  logic                 check_pass,
  input  logic                 test_done,
  output logic                 dut_rst_n,
  output logic [IDX_W-1:0]     test_sel,
  output logic                 test_go,
  output logic                 busy,
  output logic                 result_valid,
  output logic                 timed_out,
  output logic                 run_done,
  output logic [CNT_W-1:0]     cur_passed,
  output logic [CNT_W-1:0]     cur_failed,
  output logic [CNT_W-1:0]     total_passed,
  output logic [CNT_W-1:0]     total_failed
);

  localparam int RC_W = $clog2(RST_CYCLES + 1);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RESET, S_GO, S_RUN, S_REPORT, S_NEXT, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_TESTS-1:0]   mask_q;
  logic                   first_q;
  logic [RC_W-1:0]        rst_cnt;
  logic [WD_W-1:0]        wd_cnt;
  logic                   found;
  logic [IDX_W-1:0]       found_idx;
  logic                   run, wd_hit, pass_inc;
  logic [1:0]             fail_n;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  // Lowest enabled slot above the last test (any slot on the first search).
  always_comb begin
    found     = 1'b0;
    found_idx = '0;
    for (int i = NUM_TESTS-1; i >= 0; i--) begin
      if (mask_q[i] && (first_q || (IDX_W'(i) > test_sel))) begin
        found     = 1'b1;
        found_idx = IDX_W'(i);
      end
    end
  end

  assign run      = (state_q == S_RUN);
  // test_done wins over a watchdog expiry landing in the same cycle.
  assign wd_hit   = run && !test_done && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  assign pass_inc = run & check_valid & check_pass;
  assign fail_n   = {1'b0, run & check_valid & ~check_pass} + {1'b0, wd_hit};

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_NEXT;
      S_NEXT:   state_d = found ? S_RESET : S_DONE;
      S_RESET:  if (rst_cnt == RC_W'(RST_CYCLES - 1)) state_d = S_GO;
      S_GO:     state_d = S_RUN;
      S_RUN:    if (test_done || wd_hit) state_d = S_REPORT;
      S_REPORT: state_d = S_NEXT;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      dut_rst_n    <= 1'b0;
      mask_q       <= '0;
      first_q      <= 1'b0;
      test_sel     <= '0;
      rst_cnt      <= '0;
      wd_cnt       <= '0;
      timed_out    <= 1'b0;
      cur_passed   <= '0;
      cur_failed   <= '0;
      total_passed <= '0;
      total_failed <= '0;
    end else begin
      state_q   <= state_d;
      dut_rst_n <= (state_d != S_RESET);
      case (state_q)
        S_IDLE: if (start) begin
          mask_q       <= test_en;
          first_q      <= 1'b1;
          cur_passed   <= '0;
          cur_failed   <= '0;
          total_passed <= '0;
          total_failed <= '0;
        end
        S_NEXT: if (found) begin
          test_sel   <= found_idx;
          first_q    <= 1'b0;
          rst_cnt    <= '0;
          cur_passed <= '0;
          cur_failed <= '0;
          timed_out  <= 1'b0;
        end
        S_RESET: rst_cnt <= rst_cnt + 1'b1;
        S_GO:    wd_cnt  <= '0;
        S_RUN: begin
          wd_cnt       <= wd_cnt + 1'b1;
          cur_passed   <= sat_add(cur_passed,   {1'b0, pass_inc});
          total_passed <= sat_add(total_passed, {1'b0, pass_inc});
          cur_failed   <= sat_add(cur_failed,   fail_n);
          total_failed <= sat_add(total_failed, fail_n);
          if (wd_hit) timed_out <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign test_go      = (state_q == S_GO);
  assign result_valid = (state_q == S_REPORT);
  assign run_done     = (state_q == S_DONE);

endmodule

// File: tb/tb_test_sequencer.sv
// Randomized bench for test_sequencer: a per-test script model predicts every
// report and the run totals; a second instance covers counter saturation.
`timescale 1ns/1ps
module tb_test_sequencer;
  localparam int NT = 4, CW = 8, RC = 2, TMO = 16;

  logic clk = 1'b0;
  logic reset_n;
  logic start, check_valid, check_pass, test_done;
  logic [NT-1:0] test_en;
  logic dut_rst_n, test_go, busy, result_valid, timed_out, run_done;
  logic [1:0] test_sel;
  logic [CW-1:0] cur_passed, cur_failed, total_passed, total_failed;

  logic s_start, s_cv, s_cp, s_td;
  logic [NT-1:0] s_test_en;
  logic s_dut_rst_n, s_test_go, s_busy, s_rv, s_to, s_run_done;
  logic [1:0] s_test_sel;
  logic [CW-1:0] s_cur_p, s_cur_f, s_tot_p, s_tot_f;

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  test_sequencer #(.NUM_TESTS(NT), .CNT_W(CW), .RST_CYCLES(RC), .TIMEOUT_CYCLES(TMO)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .test_en(test_en),
    .check_valid(check_valid), .check_pass(check_pass), .test_done(test_done),
    .dut_rst_n(dut_rst_n), .test_sel(test_sel), .test_go(test_go), .busy(busy),
    .result_valid(result_valid), .timed_out(timed_out), .run_done(run_done),
    .cur_passed(cur_passed), .cur_failed(cur_failed),
    .total_passed(total_passed), .total_failed(total_failed));

  test_sequencer #(.NUM_TESTS(NT), .CNT_W(CW), .RST_CYCLES(RC), .TIMEOUT_CYCLES(1024)) u_sat (
    .clk(clk), .reset_n(reset_n), .start(s_start), .test_en(s_test_en),
    .check_valid(s_cv), .check_pass(s_cp), .test_done(s_td),
    .dut_rst_n(s_dut_rst_n), .test_sel(s_test_sel), .test_go(s_test_go), .busy(s_busy),
    .result_valid(s_rv), .timed_out(s_to), .run_done(s_run_done),
    .cur_passed(s_cur_p), .cur_failed(s_cur_f),
    .total_passed(s_tot_p), .total_failed(s_tot_f));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int sat(input int x);
    return (x > 255) ? 255 : x;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Traffic that a correct sequencer must ignore in its current state.
  task automatic noise();
    check_valid = 1'($urandom);
    check_pass  = 1'($urandom);
    test_done   = 1'($urandom);
    start       = 1'($urandom);
    test_en     = 4'($urandom);
  endtask

  task automatic chk_next();
    chk("next_busy", 32'(busy), 1);
    chk("next_rstn", 32'(dut_rst_n), 1);
    chk("next_go",   32'(test_go), 0);
    chk("next_rv",   32'(result_valid), 0);
    chk("next_done", 32'(run_done), 0);
    noise();
  endtask

  // kind: 0 random script, 1 three passes + one fail then done,
  // 2 never done, 3 pass and done together in the first RUN cycle.
  task automatic do_run(input logic [NT-1:0] mask, input int kind);
    int tp, tf, cp, cf, L;
    logic to, cv, pv, td;
    chk("idle_busy", 32'(busy), 0);
    start = 1'b1; test_en = mask; check_valid = 1'b0; test_done = 1'b0;
    step();
    chk_next();
    tp = 0; tf = 0;
    for (int i = 0; i < NT; i++) begin
      if (mask[i]) begin
        step();
        for (int r = 0; r < RC; r++) begin
          if (r > 0) step();
          noise();
          chk("rst_rstn", 32'(dut_rst_n), 0);
          chk("rst_go",   32'(test_go), 0);
          chk("rst_to",   32'(timed_out), 0);
          chk("rst_curp", 32'(cur_passed), 0);
          chk("rst_curf", 32'(cur_failed), 0);
        end
        step();
        noise();
        chk("go_pulse", 32'(test_go), 1);
        chk("go_rstn",  32'(dut_rst_n), 1);
        chk("go_sel",   32'(test_sel), 32'(i));
        cp = 0; cf = 0; to = 1'b0;
        L = int'($urandom_range(1, TMO + 3));
        for (int k = 1; k <= TMO; k++) begin
          step();
          chk("run_rv",   32'(result_valid), 0);
          chk("run_go",   32'(test_go), 0);
          chk("run_curp", 32'(cur_passed), 32'(sat(cp)));
          chk("run_curf", 32'(cur_failed), 32'(sat(cf)));
          chk("run_totp", 32'(total_passed), 32'(sat(tp)));
          case (kind)
            1:       begin cv = (k <= 4); pv = (k <= 3); td = (k == 5); end
            2:       begin cv = 1'b0; pv = 1'b0; td = 1'b0; end
            3:       begin cv = 1'b1; pv = 1'b1; td = 1'b1; end
            default: begin cv = 1'($urandom); pv = 1'($urandom); td = (k == L); end
          endcase
          check_valid = cv; check_pass = pv; test_done = td;
          start = 1'($urandom); test_en = 4'($urandom);
          if (cv) begin
            if (pv) begin cp++; tp++; end
            else    begin cf++; tf++; end
          end
          if (td) break;
          if (k == TMO) begin to = 1'b1; cf++; tf++; end
        end
        step();
        noise();
        chk("rep_rv",   32'(result_valid), 1);
        chk("rep_sel",  32'(test_sel), 32'(i));
        chk("rep_curp", 32'(cur_passed), 32'(sat(cp)));
        chk("rep_curf", 32'(cur_failed), 32'(sat(cf)));
        chk("rep_to",   32'(timed_out), 32'(to));
        step();
        chk_next();
      end
    end
    step();
    noise();
    chk("done_pulse", 32'(run_done), 1);
    chk("done_totp",  32'(total_passed), 32'(sat(tp)));
    chk("done_totf",  32'(total_failed), 32'(sat(tf)));
    chk("done_rstn",  32'(dut_rst_n), 1);
    step();
    start = 1'b0; check_valid = 1'b0; test_done = 1'b0;
    chk("idle_after",  32'(busy), 0);
    chk("idle_nodone", 32'(run_done), 0);
    chk("hold_totp",   32'(total_passed), 32'(sat(tp)));
    chk("hold_totf",   32'(total_failed), 32'(sat(tf)));
  endtask

  // 300 passing checks in one test on the long-watchdog instance.
  task automatic sat_scenario();
    s_start = 1'b1; s_test_en = 4'b0001;
    step(); s_start = 1'b0;
    step(); step(); step();
    chk("sat_go", 32'(s_test_go), 1);
    for (int k = 1; k <= 300; k++) begin
      step();
      if (k == 101) chk("sat_mid",  32'(s_cur_p), 100);
      if (k == 300) chk("sat_clip", 32'(s_cur_p), 255);
      s_cv = 1'b1; s_cp = 1'b1; s_td = (k == 300);
    end
    step();
    s_cv = 1'b0; s_cp = 1'b0; s_td = 1'b0;
    chk("sat_rv",   32'(s_rv), 1);
    chk("sat_curp", 32'(s_cur_p), 255);
    chk("sat_curf", 32'(s_cur_f), 0);
    chk("sat_to",   32'(s_to), 0);
    step(); step();
    chk("sat_done", 32'(s_run_done), 1);
    chk("sat_totp", 32'(s_tot_p), 255);
  endtask

  task automatic abort_scenario();
    start = 1'b1; test_en = 4'b0100;
    step(); start = 1'b0;
    step(); step(); step();
    chk("ab_go", 32'(test_go), 1);
    step(); check_valid = 1'b1; check_pass = 1'b1;
    step();
    chk("ab_curp", 32'(cur_passed), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("ab_busy", 32'(busy), 0);
    chk("ab_rstn", 32'(dut_rst_n), 0);
    chk("ab_sel",  32'(test_sel), 0);
    chk("ab_go0",  32'(test_go), 0);
    chk("ab_rv",   32'(result_valid), 0);
    chk("ab_to",   32'(timed_out), 0);
    chk("ab_rd",   32'(run_done), 0);
    chk("ab_cnt",  32'({cur_passed, cur_failed, total_passed, total_failed}), 0);
    step();
    check_valid = 1'b0;
    reset_n = 1'b1;
    chk("ab_rstn_hold", 32'(dut_rst_n), 0);
    step();
    chk("ab_rstn_rel", 32'(dut_rst_n), 1);
    for (int c = 0; c < 30; c++) begin
      noise(); start = 1'b0;
      step();
      if (result_valid || run_done || busy) chk("ab_quiet", 32'({result_valid, run_done, busy}), 0);
    end
    check_valid = 1'b0; test_done = 1'b0;
    chk("ab_quiet_end", 32'({result_valid, run_done, busy}), 0);
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0; test_en = '0; check_valid = 1'b0; check_pass = 1'b0; test_done = 1'b0;
    s_start = 1'b0; s_test_en = '0; s_cv = 1'b0; s_cp = 1'b0; s_td = 1'b0;
    step(); step();
    chk("rst_busy",  32'(busy), 0);
    chk("rst_dutn",  32'(dut_rst_n), 0);
    chk("rst_outs",  32'({test_go, result_valid, timed_out, run_done, test_sel}), 0);
    chk("rst_cnts",  32'({cur_passed, cur_failed, total_passed, total_failed}), 0);
    reset_n = 1'b1;
    chk("rel_dutn_low", 32'(dut_rst_n), 0);
    step();
    chk("rel_dutn_high", 32'(dut_rst_n), 1);

    do_run(4'b1011, 1);
    do_run(4'b0001, 2);
    do_run(4'b0100, 3);
    do_run(4'b0000, 0);
    sat_scenario();
    abort_scenario();
    do_run(4'b1000, 0);
    for (int n = 0; n < 20; n++)
      do_run(4'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected end before time limit");
    $fatal(1);
  end
endmodule
